pipelined_shifter: RTL

//  Parametrised, pipelined barrel shifter for the datapath execute stage; successor to the

---
 rtl/shifter_pkg.sv | 32 +++
 rtl/pipelined_shifter_if.sv | 29 ++
 rtl/pipelined_shifter_shift_level.sv | 29 ++
 rtl/pipelined_shifter.sv | 117 +++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op codes, the per-stage
// control record and the helpers that map log-shifter levels onto pipeline stages.
package shifter_pkg;

  localparam logic [1:0] SHOP_SRL = 2'b00;
  localparam logic [1:0] SHOP_SRA = 2'b01;
  localparam logic [1:0] SHOP_SLL = 2'b10;
  localparam logic [1:0] SHOP_ROR = 2'b11;

  // Control part of a stage's payload. Fill is the SRA sign bit captured at the
  // input, so downstream levels never need to look back at the original MSB.
  typedef struct packed {
    logic [1:0] op;
    logic       fill;
  } stage_ctrl_t;

  // Stage that hosts log-shifter level k.
  function automatic int stage_of(input int k, input int pipe, input int levels);
    return (k * pipe) / levels;
  endfunction

  // Highest-numbered level that lands in stage s; its output feeds that stage's register.
  function automatic int last_level(input int s, input int pipe, input int levels);
    int last;
    last = 0;
    for (int k = 0; k < levels; k++) begin
      if (stage_of(k, pipe, levels) == s) last = k;
    end
    return last;
  endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Request/response handshake bundle between operand select, the shifter and writeback.
interface pipelined_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_op;
  logic [SHAMT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  // Requester / consumer side.
  modport master (
    output in_valid, in_data, in_op, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_data, in_op, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_shifter_shift_level.sv
// One combinational level of the log shifter: shifts or rotates right/left by AMT
// when enabled, otherwise passes data through.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic             fill,
  input  logic             en,
  output logic [WIDTH-1:0] result
);

  // Select the shifted form of data for this level's fixed amount.
  always_comb begin
    // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
    result = data;
    if (en) begin
      case (op)
        SHOP_SRL, SHOP_SRA: result = {{AMT{fill}}, data[WIDTH-1:AMT]};
        SHOP_SLL:           result = {data[WIDTH-1-AMT:0], {AMT{1'b0}}};
        SHOP_ROR:           result = {data[AMT-1:0], data[WIDTH-1:AMT]};
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SHAMT_W log-shift levels spread over PIPE register
// stages, valid/ready handshake with backpressure, pass-through tag and flush.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int PIPE    = 3,
  parameter int TAG_W   = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  pipelined_shifter_if.slave bus
);

  logic [PIPE-1:0]    valid_q;
  logic [PIPE-1:0]    adv;
  logic [PIPE-1:0]    src_valid;
  logic [WIDTH-1:0]   data_q    [PIPE];
  stage_ctrl_t        ctrl_q    [PIPE];
  logic [SHAMT_W-1:0] shamt_q   [PIPE];
  logic [TAG_W-1:0]   tag_q     [PIPE];
  logic [WIDTH-1:0]   src_data  [PIPE];
  stage_ctrl_t        src_ctrl  [PIPE];
  logic [SHAMT_W-1:0] src_shamt [PIPE];
  logic [TAG_W-1:0]   src_tag   [PIPE];
  logic [WIDTH-1:0]   stage_d   [PIPE];
  logic [WIDTH-1:0]   lvl_out   [SHAMT_W];

  // Each stage's source is the input port (stage 0) or the previous stage register.
  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_ctrl[0]  = '{op: bus.in_op, fill: (bus.in_op == SHOP_SRA) && bus.in_data[WIDTH-1]};
    src_shamt[0] = bus.in_shamt;
    src_tag[0]   = bus.in_tag;
    for (int s = 1; s < PIPE; s++) begin
      src_valid[s] = valid_q[s-1];
      src_data[s]  = data_q[s-1];
      src_ctrl[s]  = ctrl_q[s-1];
      src_shamt[s] = shamt_q[s-1];
      src_tag[s]   = tag_q[s-1];
    end
  end

  // Stage s may load when the consumer takes the result or any stage from s onward is
  // empty; this is the unrolled form of "empty or next stage advances".
  always_comb begin
    for (int s = 0; s < PIPE; s++) begin
      logic hole;
      hole = bus.out_ready;
      for (int j = s; j < PIPE; j++) hole = hole | !valid_q[j];
      adv[s] = hole;
    end
  end

  // Log-shifter levels, each wired into the stage that hosts it.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
    localparam int  ST    = stage_of(k, PIPE, SHAMT_W);
    localparam bit  FIRST = (k == 0) ? 1'b1 : (stage_of(k - 1, PIPE, SHAMT_W) != ST);
    logic [WIDTH-1:0] lvl_in;

    if (FIRST) begin : g_first
      assign lvl_in = src_data[ST];
    end else begin : g_chain
      assign lvl_in = lvl_out[k-1];
    end

    shift_level #(.WIDTH(WIDTH), .AMT(1 << k)) u_level (
      .data   (lvl_in),
      .op     (src_ctrl[ST].op),
      .fill   (src_ctrl[ST].fill),
      .en     (src_shamt[ST][k]),
      .result (lvl_out[k])
    );
  end

  for (genvar s = 0; s < PIPE; s++) begin : g_stage_d
    assign stage_d[s] = lvl_out[last_level(s, PIPE, SHAMT_W)];
  end

  // Stage registers: flush kills every valid bit, stalled stages hold, payload loads with valid.
  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too, so out_data/out_tag read zero out of reset.
      for (int s = 0; s < PIPE; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        ctrl_q[s]  <= '0;
        shamt_q[s] <= '0;
        tag_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < PIPE; s++) begin
        if (flush) begin
          valid_q[s] <= 1'b0;
        end else if (adv[s]) begin
          valid_q[s] <= src_valid[s];
          if (src_valid[s]) begin
            data_q[s]  <= stage_d[s];
            ctrl_q[s]  <= src_ctrl[s];
            shamt_q[s] <= src_shamt[s];
            tag_q[s]   <= src_tag[s];
          end
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[PIPE-1];
  assign bus.out_data  = data_q[PIPE-1];
  assign bus.out_tag   = tag_q[PIPE-1];

endmodule
